// File: rtl/block_packer_pkg.sv
// Shared defaults and helpers for block_packer: parameter defaults, the
// blk_count width function and the word-order convention (first word in MSBs).
package block_packer_pkg;

  localparam int DEF_WORD_W        = 32;
  localparam int DEF_WORDS_PER_BLK = 4;
  localparam int DEF_BLK_DEPTH     = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Word slot 0 (the first word of a block) lands in the most significant bits.
  function automatic int slot_lsb(input int slot, input int words, input int word_w);
    return (words - 1 - slot) * word_w;
  endfunction

endpackage

// File: rtl/blk_fifo.sv
// Block FIFO for block_packer: power-of-two depth, registered pointers and count,
// head presented combinationally from storage (zero when empty).
module blk_fifo
  import block_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W * DEF_WORDS_PER_BLK,
  parameter int DEPTH = DEF_BLK_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    valid,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rptr] : '0;

  // NOTE: storage carries no reset; valid and the zeroed head cover its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/block_packer.sv
// block_packer: packs WORD_W words into WORDS_PER_BLK-word blocks queued in blk_fifo.
// Optional BLOCK_PACKER_PAD_EN: wr_last closes a partial block with zero-filled low words.
module block_packer
  import block_packer_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter int BLK_DEPTH     = DEF_BLK_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [WORD_W-1:0]               wr_data,
  input  logic                            wr_last,
  output logic                            wr_ready,
  output logic [WORD_W*WORDS_PER_BLK-1:0] blk_data,
  output logic                            blk_valid,
  input  logic                            blk_ready,
  output logic [cnt_w(BLK_DEPTH)-1:0]     blk_count,
  output logic                            overflow
);

  localparam int BLK_W = WORD_W * WORDS_PER_BLK;
  localparam int WCW   = $clog2(WORDS_PER_BLK);

  logic [WCW-1:0]   wcnt;
  logic [BLK_W-1:0] asm_q;
  logic [BLK_W-1:0] asm_next;
  logic             last_slot;
  logic             need_room;
  logic             fifo_full;
  logic             accept;
  logic             commit;

  assign last_slot = (wcnt == WCW'(WORDS_PER_BLK - 1));

`ifdef BLOCK_PACKER_PAD_EN
  assign need_room = last_slot || wr_last;
  assign commit    = accept && (last_slot || wr_last);
`else
  logic unused_wr_last;
  assign unused_wr_last = wr_last;
  assign need_room      = last_slot;
  assign commit         = accept && last_slot;
`endif

  // A pop on this edge frees the slot a committing word needs.
  assign wr_ready = !need_room || !fifo_full || blk_ready;
  assign accept   = wr_en && wr_ready;

  // NOTE: asm_next is given a default before the loop so no latch is inferred.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      if (wcnt == WCW'(i)) asm_next[slot_lsb(i, WORDS_PER_BLK, WORD_W) +: WORD_W] = wr_data;
    end
  end

  // The assembly register is cleared after each commit, so padded low words are zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt     <= '0;
      asm_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) overflow <= 1'b1;
      if (commit) begin
        wcnt  <= '0;
        asm_q <= '0;
      end else if (accept) begin
        wcnt  <= wcnt + WCW'(1);
        asm_q <= asm_next;
      end
    end
  end

  blk_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (BLK_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (commit),
    .push_data (asm_next),
    .pop       (blk_ready),
    .head      (blk_data),
    .valid     (blk_valid),
    .full      (fifo_full),
    .count     (blk_count)
  );

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: reference model plus block scoreboard.
module tb_block_packer;

  localparam int W     = 32;
  localparam int WPB   = 4;
  localparam int DEPTH = 4;
  localparam int BW    = W * WPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic [BW-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [2:0]    blk_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [BW-1:0] sb[$];
  int            m_wcnt = 0;
  int            m_cnt  = 0;
  logic [BW-1:0] m_asm  = '0;
  logic          m_ovf  = 1'b0;

  block_packer #(.WORD_W(W), .WORDS_PER_BLK(WPB), .BLK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_count (blk_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready(input logic last, input logic rdy);
    logic need_room;
    need_room = (m_wcnt == WPB - 1);
`ifdef BLOCK_PACKER_PAD_EN
    need_room = need_room || last;
`endif
    return !need_room || (m_cnt < DEPTH) || rdy;
  endfunction

  // One clock: drive, sample at negedge against the model, then advance the model.
  task automatic cycle(input logic en, input logic [W-1:0] d, input logic rdy, input logic last);
    logic acc, commit, pop;
    wr_en = en; wr_data = d; blk_ready = rdy; wr_last = last;
    @(negedge clk);
    check("wr_ready", wr_ready, m_ready(last, rdy));
    check("blk_valid", blk_valid, m_cnt != 0);
    check("blk_count", blk_count, m_cnt);
    check("count_le_depth", blk_count <= DEPTH, 1);
    check("overflow", overflow, m_ovf);
    pop = (m_cnt != 0) && rdy;
    if (blk_valid && rdy) begin
      if (sb.size() == 0) check("sb_underrun", sb.size(), 1);
      else begin
        check("blk_data", blk_data, sb.pop_front());
        pops++;
      end
    end
    acc = en && m_ready(last, rdy);
    if (en && !acc) m_ovf = 1'b1;
    commit = 1'b0;
    if (acc) begin
      m_asm[(WPB - 1 - m_wcnt) * W +: W] = d;
      commit = (m_wcnt == WPB - 1);
`ifdef BLOCK_PACKER_PAD_EN
      if (last) commit = 1'b1;
`endif
      if (commit) begin
        sb.push_back(m_asm);
        m_asm  = '0;
        m_wcnt = 0;
      end else begin
        m_wcnt++;
      end
    end
    m_cnt = m_cnt + int'(commit) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; wr_last = 1'b0; blk_ready = 1'b0; wr_data = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_valid", blk_valid, 0);
    check("rst_count", blk_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", blk_data, 0);
    sb.delete();
    m_wcnt = 0; m_cnt = 0; m_asm = '0; m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int offered;
    int budget;
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Four words with consumer ready form one block, visible one edge later.
    cycle(1'b1, 32'h00010203, 1'b1, 1'b0);
    cycle(1'b1, 32'h04050607, 1'b1, 1'b0);
    cycle(1'b1, 32'h08090A0B, 1'b1, 1'b0);
    cycle(1'b1, 32'h0C0D0E0F, 1'b1, 1'b0);
    check("req031_valid", blk_valid, 1);
    check("req031_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("req031_gone", blk_valid, 0);

    // Fill the FIFO with the consumer stalled, then three words of a fifth block.
    for (int i = 0; i < 16; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    check("req032_count", blk_count, 4);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);

    // Full FIFO, last slot, consumer ready: pop and commit on one edge.
    cycle(1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
    check("req033_count", blk_count, 4);
    check("req033_overflow", overflow, 0);

    // Stalled again: the word in the last slot is refused and dropped.
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    wr_en = 1'b1; blk_ready = 1'b0; wr_last = 1'b0;
    #1 check("req032_ready", wr_ready, 0);
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("req032_overflow", overflow, 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", sb.size(), 0);

    // Partial block discarded by reset; the next four words make exactly one block.
    cycle(1'b1, 32'h55555555, 1'b1, 1'b0);
    cycle(1'b1, 32'h66666666, 1'b1, 1'b0);
    do_reset();
    pops = 0;
    cycle(1'b1, 32'h10000001, 1'b1, 1'b0);
    cycle(1'b1, 32'h20000002, 1'b1, 1'b0);
    cycle(1'b1, 32'h30000003, 1'b1, 1'b0);
    cycle(1'b1, 32'h40000004, 1'b1, 1'b0);
    check("req034_data", blk_data, 128'h10000001200000023000000340000004);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("req034_pops", pops, 1);

`ifdef BLOCK_PACKER_PAD_EN
    cycle(1'b1, 32'h11111111, 1'b1, 1'b0);
    cycle(1'b1, 32'h22222222, 1'b1, 1'b1);
    check("req035_data", blk_data, 128'h11111111222222220000000000000000);
    cycle(1'b0, '0, 1'b1, 1'b0);
`endif

    // Random traffic with a randomly stalling consumer.
    offered = 0;
    while (offered < 100) begin
      logic en;
      logic last;
      en   = ($urandom_range(0, 3) != 0);
      last = 1'b0;
`ifdef BLOCK_PACKER_PAD_EN
      last = ($urandom_range(0, 7) == 0);
`endif
      if (en) offered++;
      cycle(en, $urandom, 1'($urandom_range(0, 1)), last);
    end
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      budget++;
    end
    check("random_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
